// File: rtl/lbp_frame_host.sv
// -----------------------------------------------------------------------------
// lbp_frame_host
//
// Frame host for the LBP engine. Accepts a square 8-bit grayscale frame over a
// byte stream, serves it to the engine through a combinational read port,
// captures the engine's result writes into a result RAM and, once the engine
// signals finish, streams the whole result frame back out in raster order.
// Border pixels are never written by the engine and are emitted as 0.
//
// Handshake rule for both streams: a byte moves on a rising edge where valid
// and ready are both high. While valid is high and ready is low, the source
// holds data (and last) steady.
//
// Optional feature: define LBP_FRAME_HOST_CHECK_EN to build the sticky
// protocol checker behind `err`. Without it, `err` is tied to 0.
//
// Ports:
//   clk, reset              : clock, synchronous active-high reset
//   start                   : one-cycle frame start pulse (honoured in IDLE)
//   pix_in_valid/ready/data : input pixel stream, raster order
//   gray_ready              : frame loaded, engine may read
//   gray_req, gray_addr     : engine read request and address
//   gray_data               : read data, same cycle as the address
//   lbp_valid/addr/data     : engine result write port
//   finish                  : engine done
//   res_out_valid/ready     : output result stream handshake
//   res_out_data/last       : output result byte, last marks final address
//   frame_done              : one-cycle pulse after the last output handshake
//   err                     : sticky protocol error (checker build only)
// -----------------------------------------------------------------------------
module lbp_frame_host #(
    parameter int IMG_W  = 128,
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              pix_in_valid,
    input  logic [7:0]        pix_in_data,
    output logic              pix_in_ready,
    output logic              gray_ready,
    input  logic              gray_req,
    input  logic [ADDR_W-1:0] gray_addr,
    output logic [7:0]        gray_data,
    input  logic              lbp_valid,
    input  logic [ADDR_W-1:0] lbp_addr,
    input  logic [7:0]        lbp_data,
    input  logic              finish,
    output logic              res_out_valid,
    output logic [7:0]        res_out_data,
    output logic              res_out_last,
    input  logic              res_out_ready,
    output logic              frame_done,
    output logic              err
);

    localparam int CW = ADDR_W / 2;
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SERVE = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [7:0] img [0:IMG_W*IMG_W-1];
    logic [7:0] res [0:IMG_W*IMG_W-1];

    logic [ADDR_W-1:0] load_cnt;
    logic [ADDR_W-1:0] drain_cnt;

    logic load_hs;
    logic drain_hs;
    logic drain_last_hs;
    logic res_wr;

    // Row lives in the upper half of the address, column in the lower half.
    function automatic logic is_border(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-CW-1:0] row;
        logic [CW-1:0]        col;
        row = a[ADDR_W-1:CW];
        col = a[CW-1:0];
        return (row == '0) || (&row) || (col == '0) || (&col);
    endfunction

    assign load_hs       = (state == LOAD) && pix_in_valid && pix_in_ready;
    assign drain_hs      = (state == DRAIN) && res_out_ready;
    assign drain_last_hs = drain_hs && (drain_cnt == LAST_ADDR);
    assign res_wr        = (state == SERVE) && lbp_valid;

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = LOAD;
            LOAD:    if (load_hs && (load_cnt == LAST_ADDR)) state_nxt = SERVE;
            SERVE:   if (finish) state_nxt = DRAIN;
            DRAIN:   if (drain_last_hs) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register, counters and registered state decodes.
    // The ready flags decode the next state so they are high exactly while
    // the state register holds LOAD / SERVE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            load_cnt     <= '0;
            drain_cnt    <= '0;
            pix_in_ready <= 1'b0;
            gray_ready   <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            state        <= state_nxt;
            pix_in_ready <= (state_nxt == LOAD);
            gray_ready   <= (state_nxt == SERVE);
            frame_done   <= drain_last_hs;
            if ((state == IDLE) && start) begin
                load_cnt  <= '0;
                drain_cnt <= '0;
            end else begin
                if (load_hs)  load_cnt  <= load_cnt + 1'b1;
                if (drain_hs) drain_cnt <= drain_cnt + 1'b1;
            end
        end
    end

    // Frame RAMs: contents survive reset; every location read is either
    // written earlier in the frame or masked as border.
    always_ff @(posedge clk) begin
        if (load_hs) img[load_cnt] <= pix_in_data;
        if (res_wr)  res[lbp_addr] <= lbp_data;
    end

    // Combinational read ports and output stream
    always_comb begin
        gray_data     = 8'd0;
        res_out_valid = 1'b0;
        res_out_data  = 8'd0;
        res_out_last  = 1'b0;
        if ((state == SERVE) && gray_req) gray_data = img[gray_addr];
        if (state == DRAIN) begin
            res_out_valid = 1'b1;
            res_out_last  = (drain_cnt == LAST_ADDR);
            if (!is_border(drain_cnt)) res_out_data = res[drain_cnt];
        end
    end

`ifdef LBP_FRAME_HOST_CHECK_EN
    localparam logic [ADDR_W-1:0] INTERIOR = ADDR_W'((IMG_W - 2) * (IMG_W - 2));

    logic [ADDR_W-1:0] wr_cnt;
    logic [ADDR_W-1:0] wr_cnt_nxt;
    logic              err_set;

    // Write count including the current cycle's write, so a write that
    // lands together with finish is part of the final tally.
    always_comb begin
        wr_cnt_nxt = wr_cnt;
        if (res_wr && (wr_cnt != LAST_ADDR)) wr_cnt_nxt = wr_cnt + 1'b1;
        err_set = (lbp_valid && is_border(lbp_addr))
               || ((lbp_valid || finish) && (state != SERVE))
               || ((state == SERVE) && finish && (wr_cnt_nxt != INTERIOR));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_cnt <= '0;
            err    <= 1'b0;
        end else begin
            if ((state == IDLE) && start) wr_cnt <= '0;
            else                          wr_cnt <= wr_cnt_nxt;
            if (err_set) err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_lbp_frame_host.sv
// -----------------------------------------------------------------------------
// tb_lbp_frame_host
//
// Bench for lbp_frame_host. Plays both the pixel source and the LBP engine.
// The engine's results come from a behavioural LBP computation over the
// bench's own copy of the loaded image; the expected output stream is built
// from that model (border bytes 0, interior bytes the LBP code).
// LBP code: bit k set when neighbour k >= centre, neighbours ordered
// top-left, top, top-right, left, right, bottom-left, bottom, bottom-right.
// -----------------------------------------------------------------------------
module tb_lbp_frame_host;

    localparam int N = 16384;

`ifdef LBP_FRAME_HOST_CHECK_EN
    localparam bit CHECK_ON = 1'b1;
`else
    localparam bit CHECK_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        pix_in_valid;
    logic [7:0]  pix_in_data;
    logic        pix_in_ready;
    logic        gray_ready;
    logic        gray_req;
    logic [13:0] gray_addr;
    logic [7:0]  gray_data;
    logic        lbp_valid;
    logic [13:0] lbp_addr;
    logic [7:0]  lbp_data;
    logic        finish;
    logic        res_out_valid;
    logic [7:0]  res_out_data;
    logic        res_out_last;
    logic        res_out_ready;
    logic        frame_done;
    logic        err;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] img_m [N];
    logic [7:0] exp_q [$];

    lbp_frame_host #(.IMG_W(128), .ADDR_W(14)) dut (
        .clk(clk), .reset(reset), .start(start),
        .pix_in_valid(pix_in_valid), .pix_in_data(pix_in_data), .pix_in_ready(pix_in_ready),
        .gray_ready(gray_ready), .gray_req(gray_req), .gray_addr(gray_addr), .gray_data(gray_data),
        .lbp_valid(lbp_valid), .lbp_addr(lbp_addr), .lbp_data(lbp_data), .finish(finish),
        .res_out_valid(res_out_valid), .res_out_data(res_out_data), .res_out_last(res_out_last),
        .res_out_ready(res_out_ready), .frame_done(frame_done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        start = 0; pix_in_valid = 0; pix_in_data = '0;
        gray_req = 0; gray_addr = '0;
        lbp_valid = 0; lbp_addr = '0; lbp_data = '0;
        finish = 0; res_out_ready = 0;
    endtask

    task automatic pulse_start();
        start = 1;
        step();
        start = 0;
    endtask

    function automatic logic [7:0] lbp_at(input int r, input int c);
        int dr [8] = '{-1, -1, -1, 0, 0, 1, 1, 1};
        int dc [8] = '{-1, 0, 1, -1, 1, -1, 0, 1};
        logic [7:0] g;
        logic [7:0] code;
        g = img_m[r * 128 + c];
        code = '0;
        for (int k = 0; k < 8; k++)
            if (img_m[(r + dr[k]) * 128 + (c + dc[k])] >= g) code[k] = 1'b1;
        return code;
    endfunction

    // ---------------------------------------------------------------- reset
    task automatic test_reset();
        logic [22:0] obs;
        drive_idle();
        reset = 1;
        step(); step();
        reset = 0;
        gray_req = 1; gray_addr = 14'h1234;
        #1;
        obs = {pix_in_ready, gray_ready, gray_data, res_out_valid, res_out_data,
               res_out_last, frame_done, err};
        n_cmp++;
        if (obs !== 23'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got %h, want 000000", obs);
        end
        gray_req = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            n_cmp++;
            if (pix_in_ready !== 1'b0) begin
                n_err++;
                $display("FAIL idle_no_start cycle %0d: pix_in_ready=%b, want 0", i, pix_in_ready);
            end
        end
    endtask

    // ---------------------------------------------------------------- err
    task automatic test_check_err();
        step();
        lbp_valid = 1; lbp_addr = 14'h0005; lbp_data = 8'($urandom_range(0, 255));
        step();
        lbp_valid = 0;
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (err !== CHECK_ON) begin
                n_err++;
                $display("FAIL err_sticky cycle %0d: err=%b, want %b", i, err, CHECK_ON);
            end
            step();
        end
        reset = 1;
        step();
        reset = 0;
        n_cmp++;
        if (err !== 1'b0) begin
            n_err++;
            $display("FAIL err_cleared_by_reset: err=%b, want 0", err);
        end
    endtask

    // ---------------------------------------------------------------- abort
    task automatic test_reset_abort();
        int cnt = 0;
        int cyc = 0;
        pulse_start();
        while (cnt < 8000 && cyc < 9000) begin
            pix_in_valid = 1;
            pix_in_data  = ~cnt[7:0];
            #1;
            if (pix_in_ready) cnt++;
            step();
            cyc++;
        end
        n_cmp++;
        if (cnt != 8000) begin
            n_err++;
            $display("FAIL abort_load_count: accepted %0d, want 8000", cnt);
        end
        reset = 1;
        step();
        reset = 0;
        pix_in_valid = 0;
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if ({pix_in_ready, gray_ready, frame_done, res_out_valid} !== 4'b0000) begin
                n_err++;
                $display("FAIL abort_idle cycle %0d: ready/gray/done/valid=%b, want 0000", i,
                         {pix_in_ready, gray_ready, frame_done, res_out_valid});
            end
            step();
        end
    endtask

    // ---------------------------------------------------------------- load
    task automatic test_load();
        int cnt = 0;
        int cyc = 0;
        bit early = 0;
        int a;
        pulse_start();
        while (cnt < N && cyc < 24000) begin
            pix_in_valid = ($urandom_range(0, 7) != 0);
            pix_in_data  = cnt[7:0];
            #1;
            if (gray_ready) early = 1;
            if (pix_in_valid && pix_in_ready) begin
                img_m[cnt] = cnt[7:0];
                cnt++;
            end
            step();
            cyc++;
        end
        pix_in_valid = 0;
        n_cmp++;
        if (cnt != N) begin
            n_err++;
            $display("FAIL load_count: accepted %0d, want %0d", cnt, N);
        end
        n_cmp++;
        if (early) begin
            n_err++;
            $display("FAIL gray_ready_early: seen 1 during load, want 0");
        end
        n_cmp++;
        if ({gray_ready, pix_in_ready} !== 2'b10) begin
            n_err++;
            $display("FAIL serve_entry: gray_ready,pix_in_ready=%b, want 10", {gray_ready, pix_in_ready});
        end
        gray_req = 1; gray_addr = 14'h1234;
        #1;
        n_cmp++;
        if (gray_data !== 8'h34) begin
            n_err++;
            $display("FAIL gray_1234: got %h, want 34", gray_data);
        end
        step();
        for (int i = 0; i < 64; i++) begin
            a = $urandom_range(0, N - 1);
            gray_addr = 14'(a);
            #1;
            n_cmp++;
            if (gray_data !== img_m[a]) begin
                n_err++;
                $display("FAIL gray_read addr %h: got %h, want %h", a, gray_data, img_m[a]);
            end
            step();
        end
        gray_req = 0;
        #1;
        n_cmp++;
        if (gray_data !== 8'd0) begin
            n_err++;
            $display("FAIL gray_no_req: got %h, want 00", gray_data);
        end
    endtask

    // ---------------------------------------------------------------- engine
    task automatic test_engine_writes();
        for (int a = 0; a < N; a++) begin
            int r = a / 128;
            int c = a % 128;
            if (r == 0 || r == 127 || c == 0 || c == 127) exp_q.push_back(8'd0);
            else exp_q.push_back(lbp_at(r, c));
        end
        for (int r = 1; r < 127; r++) begin
            for (int c = 1; c < 127; c++) begin
                if ($urandom_range(0, 31) == 0) begin
                    lbp_valid = 0;
                    lbp_addr  = 14'($urandom_range(0, N - 1));
                    lbp_data  = 8'($urandom_range(0, 255));
                    step();
                end
                lbp_valid = 1;
                lbp_addr  = 14'(r * 128 + c);
                lbp_data  = lbp_at(r, c);
                finish    = (r == 126 && c == 126);
                step();
            end
        end
        lbp_valid = 0;
        finish = 0;
        gray_req = 1; gray_addr = 14'h1234;
        #1;
        n_cmp++;
        if ({gray_ready, res_out_valid, gray_data} !== {2'b01, 8'h00}) begin
            n_err++;
            $display("FAIL drain_entry: gray_ready,valid,gray_data=%b,%b,%h, want 0,1,00",
                     gray_ready, res_out_valid, gray_data);
        end
        gray_req = 0;
    endtask

    // ---------------------------------------------------------------- drain
    task automatic test_drain();
        int idx = 0;
        int cyc = 0;
        bit held = 0;
        bit done_early = 0;
        logic [7:0] held_data = '0;
        logic       held_last = 0;
        logic [7:0] e;
        while (idx < N && cyc < 40000) begin
            res_out_ready = (cyc % 2 == 0);
            #1;
            if (frame_done) done_early = 1;
            n_cmp++;
            if (res_out_valid !== 1'b1) begin
                n_err++;
                $display("FAIL drain_valid byte %0d: valid=%b, want 1", idx, res_out_valid);
            end
            if (held) begin
                n_cmp++;
                if ({res_out_data, res_out_last} !== {held_data, held_last}) begin
                    n_err++;
                    $display("FAIL stall_stable byte %0d: got %h/%b, want %h/%b", idx,
                             res_out_data, res_out_last, held_data, held_last);
                end
            end
            if (res_out_ready && res_out_valid) begin
                e = exp_q.pop_front();
                n_cmp++;
                if (res_out_data !== e) begin
                    n_err++;
                    $display("FAIL drain_data byte %0d: got %h, want %h", idx, res_out_data, e);
                end
                n_cmp++;
                if (res_out_last !== (idx == N - 1)) begin
                    n_err++;
                    $display("FAIL drain_last byte %0d: got %b, want %b", idx, res_out_last, idx == N - 1);
                end
                idx++;
                held = 0;
            end else begin
                held = 1;
                held_data = res_out_data;
                held_last = res_out_last;
            end
            step();
            cyc++;
        end
        res_out_ready = 0;
        n_cmp++;
        if (idx != N) begin
            n_err++;
            $display("FAIL drain_count: drained %0d, want %0d", idx, N);
        end
        n_cmp++;
        if (done_early) begin
            n_err++;
            $display("FAIL frame_done_early: seen 1 during drain, want 0");
        end
        n_cmp++;
        if ({frame_done, res_out_valid} !== 2'b10) begin
            n_err++;
            $display("FAIL frame_done_pulse: done,valid=%b, want 10", {frame_done, res_out_valid});
        end
        step();
        n_cmp++;
        if ({frame_done, res_out_valid, pix_in_ready, err} !== 4'b0000) begin
            n_err++;
            $display("FAIL after_frame: done,valid,pix_ready,err=%b, want 0000",
                     {frame_done, res_out_valid, pix_in_ready, err});
        end
    endtask

    initial begin
        reset = 1;
        drive_idle();
        test_reset();
        test_check_err();
        test_reset_abort();
        test_load();
        test_engine_writes();
        test_drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
